mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory port between the pipeline's instruction-fetch requester (IF) and the data-access requester (MEM stage loads/stores). Sequences each access through a request/acknowledge handshake with memory, returns read data to the owning requester, and generates the IF and MEM stall signals that freeze the pipeline while an access is pending. Sits between the core top level and the unified memory.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory port arbiter
package mem_arb_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  function automatic arb_state_e busy_state(owner_e own);
    return (own == OWN_IF) ? FETCH : DATA;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter between fetch and data requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STREAK);

  arb_state_e          state_q, state_d;
  owner_e              winner;
  logic                grant;
  logic                if_elig, d_elig;
  logic                if_valid_q;
  logic                discard_q;
  logic [STREAK_W-1:0] streak_q;

  // A requester retiring this cycle must not be re-granted on its stale request.
  assign if_elig = if_req & ~if_valid_q & ~flush;
  assign d_elig  = d_req & ~d_valid;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = OWN_D;
    case (state_q)
      IDLE: begin
        if (if_elig && (!d_elig || streak_q == STREAK_MAX)) begin
          grant  = 1'b1;
          winner = OWN_IF;
        end else if (d_elig) begin
          grant  = 1'b1;
          winner = OWN_D;
        end
        if (grant) state_d = busy_state(winner);
      end
      FETCH, DATA: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid_q <= 1'b0;
      d_valid    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      streak_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= 1'b0;
      d_valid    <= 1'b0;

      if (grant) begin
        mem_req <= 1'b1;
        if (winner == OWN_IF) begin
          mem_we   <= 1'b0;
          mem_addr <= if_addr;
        end else begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end
      end else if (state_q != IDLE && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      // A flushed fetch still has to finish on memory; only its result is dropped.
      if (state_q == FETCH) begin
        if (mem_ack) begin
          if_rdata   <= mem_rdata;
          if_valid_q <= ~(discard_q | flush);
          discard_q  <= 1'b0;
        end else if (flush) begin
          discard_q <= 1'b1;
        end
      end

      if (state_q == DATA && mem_ack) begin
        d_rdata <= mem_rdata;
        d_valid <= 1'b1;
      end

      if ((grant && winner == OWN_IF) || !if_req) begin
        streak_q <= '0;
      end else if (grant && winner == OWN_D && streak_q != STREAK_MAX) begin
        streak_q <= streak_q + STREAK_W'(1);
      end
    end
  end

  assign if_valid  = if_valid_q & ~flush;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STREAK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, flush, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, stall_if, stall_mem;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK(STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: which requester owns memory (0 none, 1 fetch, 2 data) and what it sees
  int          m_owner;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
  bit          m_we, m_ifv, m_dv, m_dr_known, m_discard, m_chk_zero;
  int          m_streak;

  // memory responder and stimulus controls
  bit          mem_busy;
  int          mem_cnt;
  int          force_lat = -1;
  bit          force_rdata_en = 1'b0;
  logic [31:0] force_rdata;
  bit          stray_en = 1'b0, stray_force = 1'b0;
  bit          last_ifv, last_dv, prev_flush;

  // observed DUT values from the latest step
  bit          obs_ifv, obs_dv, obs_req, last_req_we;
  logic [31:0] obs_addr, last_req_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
    m_ifv = 1'b0; m_dv = 1'b0; m_ifr = '0; m_dr = '0; m_dr_known = 1'b1;
    m_streak = 0; m_discard = 1'b0; m_chk_zero = 1'b1;
  endtask

  task automatic step();
    bit exp_req, ifv_now, if_ok, d_ok, fw, dw, n_ifv, n_dv;
    exp_req = (m_owner != 0);
    if (exp_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end
      mem_ack = (mem_cnt == 0);
      if (mem_cnt == 0) mem_busy = 1'b0;
      else mem_cnt--;
    end else begin
      mem_busy = 1'b0;
      mem_ack  = stray_force || (stray_en && $urandom_range(0, 7) == 0);
    end
    mem_rdata = force_rdata_en ? force_rdata : $urandom;
    #2;
    ifv_now = m_ifv && !flush;
    check("mem_req", 64'(mem_req), 64'(exp_req));
    if (exp_req) begin
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_we", 64'(mem_we), 64'(m_we));
      if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    if (m_chk_zero) begin
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      check("rst_mem_we", 64'(mem_we), 64'(0));
    end
    check("if_valid", 64'(if_valid), 64'(ifv_now));
    check("d_valid", 64'(d_valid), 64'(m_dv));
    check("stall_if", 64'(stall_if), 64'(if_req && !ifv_now));
    check("stall_mem", 64'(stall_mem), 64'(d_req && !m_dv));
    check("if_rdata", 64'(if_rdata), 64'(m_ifr));
    if (m_dr_known) check("d_rdata", 64'(d_rdata), 64'(m_dr));
    obs_ifv = if_valid; obs_dv = d_valid; obs_req = mem_req; obs_addr = mem_addr;
    if (mem_req) begin last_req_we = mem_we; last_req_wdata = mem_wdata; end
    last_ifv = ifv_now; last_dv = m_dv;

    if_ok = if_req && !m_ifv && !flush;
    d_ok  = d_req && !m_dv;
    fw = 1'b0; dw = 1'b0;
    if (m_owner == 0) begin
      fw = if_ok && (!d_ok || m_streak == STREAK);
      dw = d_ok && !fw;
    end
    n_ifv = 1'b0; n_dv = 1'b0;
    if (m_owner == 1 && mem_ack) begin
      m_ifr = mem_rdata; n_ifv = !(m_discard || flush); m_discard = 1'b0; m_owner = 0;
    end else if (m_owner == 1 && flush) begin
      m_discard = 1'b1;
    end
    if (m_owner == 2 && mem_ack) begin
      m_dr = mem_rdata; m_dr_known = !m_we; n_dv = 1'b1; m_owner = 0;
    end
    if (fw) begin m_owner = 1; m_addr = if_addr; m_we = 1'b0; end
    if (dw) begin m_owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; end
    if (fw || !if_req) m_streak = 0;
    else m_streak = (m_streak + int'(dw) > STREAK) ? STREAK : m_streak + int'(dw);
    m_ifv = n_ifv; m_dv = n_dv; m_chk_zero = 1'b0;
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit which_d, input int maxc, output int lat);
    lat = -1;
    for (int i = 0; i <= maxc; i++) begin
      step();
      if (which_d ? obs_dv : obs_ifv) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 16383)) << 2;
  endfunction

  task automatic drive_random();
    rst = ($urandom_range(0, 199) == 0);
    if (if_req && last_ifv) if_req = 1'b0;
    if (d_req && last_dv) d_req = 1'b0;
    if (prev_flush && if_req) if_addr = rnd_addr();
    if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = rnd_addr();
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1; d_we = 1'($urandom); d_addr = rnd_addr(); d_wdata = $urandom;
    end
    flush = ($urandom_range(0, 9) == 0);
    prev_flush = flush;
  endtask

  initial begin
    int lat, cnt;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; force_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();

    // fetch only, ack 3 cycles after mem_req
    force_lat = 3; force_rdata_en = 1'b1; force_rdata = 32'h00500093;
    if_req = 1'b1; if_addr = 32'h100;
    wait_valid(1'b0, 12, lat);
    check("fetch_latency", 64'(lat), 64'(5));
    check("fetch_rdata", 64'(if_rdata), 64'(32'h00500093));
    if_req = 1'b0; force_rdata_en = 1'b0;
    step();

    // simultaneous requests: data first, fetch granted in the data valid cycle
    force_lat = 1;
    if_req = 1'b1; if_addr = 32'h180;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    wait_valid(1'b1, 12, lat);
    check("both_data_latency", 64'(lat), 64'(3));
    d_req = 1'b0;
    wait_valid(1'b0, 12, lat);
    check("both_fetch_latency", 64'(lat), 64'(2));
    if_req = 1'b0;
    step();

    // streak: data keeps winning below STREAK, fetch forced at STREAK
    force_lat = 0;
    if_req = 1'b1; if_addr = 32'h400;
    for (int k = 0; k < 4; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000 + 32'(k * 4);
      flush = (k != 3);
      step();
      flush = 1'b1;
      wait_valid(1'b1, 8, lat);
      check("streak_data_latency", 64'(lat), 64'(1));
    end
    flush = 1'b0; d_addr = 32'h6000;
    step();
    step();
    check("streak_fetch_wins", 64'(obs_addr), 64'(32'h400));
    wait_valid(1'b0, 8, lat);
    check("streak_fetch_latency", 64'(lat), 64'(0));
    if_req = 1'b0;
    wait_valid(1'b1, 8, lat);
    check("streak_next_data", 64'(lat), 64'(1));
    d_req = 1'b0;
    step();

    // flush mid-fetch discards the result; next fetch completes normally
    force_lat = 3;
    if_req = 1'b1; if_addr = 32'h300;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; if_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_ifv) cnt++;
    end
    check("flush_no_valid", 64'(cnt), 64'(0));
    check("flush_idle", 64'(obs_req), 64'(0));
    force_lat = 0; force_rdata_en = 1'b1; force_rdata = 32'h12345678;
    if_req = 1'b1; if_addr = 32'h200;
    wait_valid(1'b0, 8, lat);
    check("refetch_latency", 64'(lat), 64'(2));
    check("refetch_rdata", 64'(if_rdata), 64'(32'h12345678));
    if_req = 1'b0; force_rdata_en = 1'b0;
    step();

    // store with zero-latency ack
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF;
    wait_valid(1'b1, 8, lat);
    check("store_latency", 64'(lat), 64'(2));
    check("store_we", 64'(last_req_we), 64'(1));
    check("store_wdata", 64'(last_req_wdata), 64'(32'hDEADBEEF));
    d_req = 1'b0; d_we = 1'b0;
    step();

    // reset mid-DATA abandons the access; stray acks afterwards are ignored
    force_lat = 40;
    d_req = 1'b1; d_addr = 32'h2400;
    step();
    step();
    step();
    rst = 1'b1; d_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("reset_mem_req", 64'(obs_req), 64'(0));
    stray_force = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs_ifv || obs_dv) cnt++;
    end
    check("stray_ack_no_valid", 64'(cnt), 64'(0));
    stray_force = 1'b0;

    // randomized traffic against the model
    force_lat = -1; stray_en = 1'b1; prev_flush = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
